// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 raster constants, counter type and window helpers
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    localparam bit SYNC_POL_DEF = 1'b0;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic int span_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction

    localparam int H_TOTAL_DEF = span_total(H_ACTIVE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int V_TOTAL_DEF = span_total(V_ACTIVE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

    // Half-open window [lo, lo+len) on a raster counter.
    function automatic logic in_span(input cnt_t v, input int lo, input int len);
        return (int'(v) >= lo) && (int'(v) < lo + len);
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop single-bit synchroniser with asynchronous active-low clear
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator gated by a synchronised PLL lock
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter bit SYNC_POL = SYNC_POL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_clk_lock,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL  = span_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL  = span_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam bit SYNC_IDLE = ~SYNC_POL;

    logic lock_s;

    sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (pix_clk_lock),
        .q     (lock_s)
    );

    cnt_t h_cnt_q, h_cnt_d;
    cnt_t v_cnt_q, v_cnt_d;
    logic h_wrap, v_wrap;

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic de_q, de_d;
    cnt_t x_q, x_d;
    cnt_t y_q, y_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    always_comb begin
        h_wrap  = (h_cnt_q == cnt_t'(H_TOTAL - 1));
        v_wrap  = (v_cnt_q == cnt_t'(V_TOTAL - 1));
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (lock_s) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + cnt_t'(1);
            v_cnt_d = v_cnt_q;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + cnt_t'(1);
            end
        end
    end

    // Outputs decode the pre-increment counters, so they trail the counters by one clock.
    always_comb begin
        de_d          = lock_s && in_span(h_cnt_q, 0, H_ACTIVE) && in_span(v_cnt_q, 0, V_ACTIVE);
        hsync_d       = (lock_s && in_span(h_cnt_q, HS_START, H_SYNC)) ? SYNC_POL : SYNC_IDLE;
        vsync_d       = (lock_s && in_span(v_cnt_q, VS_START, V_SYNC)) ? SYNC_POL : SYNC_IDLE;
        x_d           = de_d ? h_cnt_q : '0;
        y_d           = de_d ? v_cnt_q : '0;
        line_start_d  = de_d && (h_cnt_q == '0);
        frame_start_d = line_start_d && (v_cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed self-checking bench for vga_timing (full 640x480 and a reduced raster)
module tb_vga_timing;

    logic clk;
    logic rst_n;
    logic lock;

    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [9:0] s_x, s_y;

    // Reduced raster: 16+4+6+4 = 30 clk/line, 8+2+2+3 = 15 lines, 450 clk/frame.
    vga_timing u_full (
        .clk          (clk),
        .rst          (rst_n),
        .pix_clk_lock (lock),
        .hsync        (d_hs),
        .vsync        (d_vs),
        .de           (d_de),
        .x            (d_x),
        .y            (d_y),
        .line_start   (d_ls),
        .frame_start  (d_fs)
    );

    vga_timing #(
        .H_ACTIVE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (4),
        .V_ACTIVE (8),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .SYNC_POL (1'b0)
    ) u_small (
        .clk          (clk),
        .rst          (rst_n),
        .pix_clk_lock (lock),
        .hsync        (s_hs),
        .vsync        (s_vs),
        .de           (s_de),
        .x            (s_x),
        .y            (s_y),
        .line_start   (s_ls),
        .frame_start  (s_fs)
    );

    localparam logic [24:0] IDLE  = {2'b11, 23'd0};
    localparam logic [22:0] START = {3'b111, 20'd0};

    int total = 0;
    int bad   = 0;

    int ls_cnt_f, ls_last_f, ls_gmin_f, ls_gmax_f, de_line_f, last_de_f, hs_low_f, hs_first_f, vs_low_f;
    int ls_cnt_s, ls_last_s, ls_gmin_s, ls_gmax_s, fs_cnt_s, fs_last_s, fs_gap_s;
    int de_frame_s, vs_low_s, vs_first_s, hs_low_s, hs_first_s;
    int found, glitch;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        lock  = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_idle_full",  {d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs}, IDLE);
        chk("rst_idle_small", {s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs}, IDLE);

        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_edge1_de", {d_de, d_fs}, 2'b00);
        @(negedge clk);
        chk("rel_edge2_de", {d_de, d_fs}, 2'b00);
        @(negedge clk);
        chk("rel_edge3_full",  {d_fs, d_ls, d_de, d_x, d_y}, START);
        chk("rel_edge3_small", {s_fs, s_ls, s_de, s_x, s_y}, START);

        ls_cnt_f = 0; ls_last_f = -1; ls_gmin_f = 99999; ls_gmax_f = 0;
        de_line_f = 0; last_de_f = -1; hs_low_f = 0; hs_first_f = -1; vs_low_f = 0;
        ls_cnt_s = 0; ls_last_s = -1; ls_gmin_s = 99999; ls_gmax_s = 0;
        fs_cnt_s = 0; fs_last_s = -1; fs_gap_s = 0;
        de_frame_s = 0; vs_low_s = 0; vs_first_s = -1; hs_low_s = 0; hs_first_s = -1;

        for (int i = 0; i < 1700; i++) begin
            if (i > 0) @(negedge clk);
            if (d_ls) begin
                ls_cnt_f++;
                if (ls_last_f >= 0) begin
                    if (i - ls_last_f < ls_gmin_f) ls_gmin_f = i - ls_last_f;
                    if (i - ls_last_f > ls_gmax_f) ls_gmax_f = i - ls_last_f;
                end
                ls_last_f = i;
            end
            if (i < 800 && d_de) begin de_line_f++; last_de_f = i; end
            if (i < 800 && !d_hs) begin hs_low_f++; if (hs_first_f < 0) hs_first_f = i; end
            if (!d_vs) vs_low_f++;
            if (i == 639) chk("full_x639", {d_de, d_x, d_y}, {1'b1, 10'd639, 10'd0});
            if (i == 640) chk("full_x640_blank", {d_de, d_x, d_ls}, 12'd0);

            if (i < 450 && s_ls) begin
                ls_cnt_s++;
                if (ls_last_s >= 0) begin
                    if (i - ls_last_s < ls_gmin_s) ls_gmin_s = i - ls_last_s;
                    if (i - ls_last_s > ls_gmax_s) ls_gmax_s = i - ls_last_s;
                end
                ls_last_s = i;
            end
            if (i < 900 && s_fs) begin
                fs_cnt_s++;
                if (fs_last_s >= 0) fs_gap_s = i - fs_last_s;
                fs_last_s = i;
            end
            if (i < 450 && s_de) de_frame_s++;
            if (i < 450 && !s_vs) begin vs_low_s++; if (vs_first_s < 0) vs_first_s = i; end
            if (i < 30 && !s_hs) begin hs_low_s++; if (hs_first_s < 0) hs_first_s = i; end
            if (i == 225) chk("small_last_pix", {s_de, s_x, s_y}, {1'b1, 10'd15, 10'd7});
            if (i == 226) chk("small_after_last_pix", {s_de, s_x, s_y}, 21'd0);
            if (i == 449) chk("small_wrap_last", {s_de, s_fs, s_ls, s_hs, s_vs}, 5'b00011);
            if (i == 450) chk("small_wrap_first", {s_fs, s_ls, s_de, s_x, s_y}, START);
        end

        chk("full_ls_count", ls_cnt_f, 3);
        chk("full_ls_gap_min", ls_gmin_f, 800);
        chk("full_ls_gap_max", ls_gmax_f, 800);
        chk("full_de_per_line", de_line_f, 640);
        chk("full_last_de", last_de_f, 639);
        chk("full_hs_low_len", hs_low_f, 96);
        chk("full_hs_first_low", hs_first_f, 656);
        chk("full_vs_stays_high", vs_low_f, 0);
        chk("small_ls_count", ls_cnt_s, 8);
        chk("small_ls_gap_min", ls_gmin_s, 30);
        chk("small_ls_gap_max", ls_gmax_s, 30);
        chk("small_fs_count", fs_cnt_s, 2);
        chk("small_fs_gap", fs_gap_s, 450);
        chk("small_de_per_frame", de_frame_s, 128);
        chk("small_vs_low_len", vs_low_s, 60);
        chk("small_vs_first_low", vs_first_s, 300);
        chk("small_hs_low_len", hs_low_s, 6);
        chk("small_hs_first_low", hs_first_s, 20);

        found = 0;
        for (int k = 0; k < 500 && found == 0; k++) begin
            @(negedge clk);
            if (s_de && s_x == 10'd10 && s_y == 10'd5) found = 1;
        end
        chk("wait_small_x10_y5", found, 1);
        lock = 1'b0;
        @(negedge clk);
        chk("drop_edge1_x", {s_de, s_x}, {1'b1, 10'd11});
        @(negedge clk);
        chk("drop_edge2_x", {s_de, s_x}, {1'b1, 10'd12});
        @(negedge clk);
        chk("drop_edge3_idle_small", {s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs}, IDLE);
        chk("drop_edge3_idle_full",  {d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs}, IDLE);
        repeat (5) @(negedge clk);
        chk("drop_hold_idle_small", {s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs}, IDLE);

        lock = 1'b1;
        @(negedge clk);
        chk("relock_edge1_fs", {s_fs, s_de}, 2'b00);
        @(negedge clk);
        chk("relock_edge2_fs", {s_fs, s_de}, 2'b00);
        @(negedge clk);
        chk("relock_edge3_small", {s_fs, s_ls, s_de, s_x, s_y}, START);
        chk("relock_edge3_full",  {d_fs, d_ls, d_de, d_x, d_y}, START);

        found = 0;
        for (int k = 0; k < 1000 && found == 0; k++) begin
            @(negedge clk);
            if (d_de && d_x == 10'd639) found = 1;
        end
        chk("wait_full_x639", found, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_idle_full",  {d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs}, IDLE);
        chk("async_rst_idle_small", {s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs}, IDLE);
        glitch = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (d_ls || s_ls || d_de || d_fs) glitch++;
        end
        chk("rst_no_line_start_glitch", glitch, 0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("rerel_edge1_fs", d_fs, 1'b0);
        @(negedge clk);
        chk("rerel_edge2_fs", d_fs, 1'b0);
        @(negedge clk);
        chk("rerel_edge3_full", {d_fs, d_ls, d_de, d_x, d_y}, START);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
